// File: rtl/nastawa_czasu.sv
`default_nettype none
// ============================================================================
//  Module   : nastawa_czasu
//  Purpose  : Operator time entry (00:00..99:59) from four debounced buttons,
//             published as a registered 13-bit seconds value.
//  Revision : 1.0 - initial release
// ============================================================================
module nastawa_czasu #(
    parameter int DEB_CYC    = 2_000_000,
    parameter int REP_DELAY  = 50_000_000,
    parameter int REP_PERIOD = 10_000_000
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_Gora,
    input  logic        i_Dol,
    input  logic        i_Wybor,
    input  logic        i_Zatwierdz,
    output logic [12:0] o_Czas,
    output logic        o_Edycja,
    output logic        o_Pole,
    output logic        o_Gotowe
);

    localparam int C_NBTN  = 4;
    localparam int C_GORA  = 0;
    localparam int C_DOL   = 1;
    localparam int C_WYBOR = 2;
    localparam int C_ZATW  = 3;
    localparam int C_DW    = $clog2(DEB_CYC + 1);
    localparam int C_RW    = $clog2(REP_DELAY + 1);

    localparam logic [C_DW-1:0] C_DEB_LAST   = C_DW'(DEB_CYC - 1);
    localparam logic [C_RW-1:0] C_REP_TOP    = C_RW'(REP_DELAY);
    localparam logic [C_RW-1:0] C_REP_RELOAD = C_RW'(REP_DELAY - REP_PERIOD + 1);

    typedef enum logic [1:0] {
        SPOCZYNEK  = 2'd0,
        EDYCJA_SEK = 2'd1,
        EDYCJA_MIN = 2'd2
    } stan_t;

    logic [C_NBTN-1:0] w_raw;
    logic [C_NBTN-1:0] w_ev;

    assign w_raw = {i_Zatwierdz, i_Wybor, i_Dol, i_Gora};

    for (genvar g = 0; g < C_NBTN; g++) begin : g_btn
        logic            r_sync1_q;
        logic            r_sync2_q;
        logic            r_deb_q;
        logic            r_deb_prev_q;
        logic [C_DW-1:0] r_dcnt_q;
        logic            w_rep;

        // Any cycle where the synchronised input agrees with the debounced level restarts the count.
        always_ff @(posedge i_CLK) begin
            if (i_RST) begin
                r_sync1_q    <= 1'b0;
                r_sync2_q    <= 1'b0;
                r_deb_q      <= 1'b0;
                r_deb_prev_q <= 1'b0;
                r_dcnt_q     <= '0;
            end else begin
                r_sync1_q    <= w_raw[g];
                r_sync2_q    <= r_sync1_q;
                r_deb_prev_q <= r_deb_q;
                if (r_sync2_q == r_deb_q) begin
                    r_dcnt_q <= '0;
                end else if (r_dcnt_q == C_DEB_LAST) begin
                    r_deb_q  <= r_sync2_q;
                    r_dcnt_q <= '0;
                end else begin
                    r_dcnt_q <= r_dcnt_q + C_DW'(1);
                end
            end
        end

        if (g == C_GORA || g == C_DOL) begin : g_rep
            logic [C_RW-1:0] r_rcnt_q;

            // Counts cycles since the press event; reloading keeps later repeats REP_PERIOD apart.
            always_ff @(posedge i_CLK) begin
                if (i_RST || !r_deb_q) begin
                    r_rcnt_q <= '0;
                end else if (r_rcnt_q == C_REP_TOP) begin
                    r_rcnt_q <= C_REP_RELOAD;
                end else begin
                    r_rcnt_q <= r_rcnt_q + C_RW'(1);
                end
            end

            assign w_rep = r_deb_q && (r_rcnt_q == C_REP_TOP);
        end else begin : g_norep
            assign w_rep = 1'b0;
        end

        assign w_ev[g] = (r_deb_q & ~r_deb_prev_q) | w_rep;
    end

    stan_t       r_stan_q;
    stan_t       w_stan_d;
    logic [5:0]  r_sek_q;
    logic [5:0]  w_sek_d;
    logic [6:0]  r_min_q;
    logic [6:0]  w_min_d;
    logic        r_gotowe_q;
    logic        w_gotowe_d;
    logic [12:0] r_czas_q;
    logic        w_gora;
    logic        w_dol;

    assign w_gora = w_ev[C_GORA] & ~w_ev[C_DOL];
    assign w_dol  = w_ev[C_DOL]  & ~w_ev[C_GORA];

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_stan_q   <= SPOCZYNEK;
            r_sek_q    <= '0;
            r_min_q    <= '0;
            r_gotowe_q <= 1'b0;
            r_czas_q   <= '0;
        end else begin
            r_stan_q   <= w_stan_d;
            r_sek_q    <= w_sek_d;
            r_min_q    <= w_min_d;
            r_gotowe_q <= w_gotowe_d;
            r_czas_q   <= {6'd0, r_min_q} * 13'd60 + {7'd0, r_sek_q};
        end
    end

    // A step and a confirm in the same cycle both take effect: the stepped value is committed.
    always_comb begin
        w_stan_d   = r_stan_q;
        w_sek_d    = r_sek_q;
        w_min_d    = r_min_q;
        w_gotowe_d = 1'b0;
        case (r_stan_q)
            SPOCZYNEK: begin
                if (w_ev[C_WYBOR]) begin
                    w_stan_d = EDYCJA_SEK;
                end
            end
            EDYCJA_SEK, EDYCJA_MIN: begin
                if (r_stan_q == EDYCJA_SEK) begin
                    if (w_gora) begin
                        w_sek_d = (r_sek_q == 6'd59) ? 6'd0 : r_sek_q + 6'd1;
                    end else if (w_dol) begin
                        w_sek_d = (r_sek_q == 6'd0) ? 6'd59 : r_sek_q - 6'd1;
                    end
                end else begin
                    if (w_gora) begin
                        w_min_d = (r_min_q == 7'd99) ? 7'd0 : r_min_q + 7'd1;
                    end else if (w_dol) begin
                        w_min_d = (r_min_q == 7'd0) ? 7'd99 : r_min_q - 7'd1;
                    end
                end
                if (w_ev[C_ZATW]) begin
                    w_stan_d   = SPOCZYNEK;
                    w_gotowe_d = 1'b1;
                end else if (w_ev[C_WYBOR]) begin
                    w_stan_d = (r_stan_q == EDYCJA_SEK) ? EDYCJA_MIN : EDYCJA_SEK;
                end
            end
            default: begin
                w_stan_d = SPOCZYNEK;
            end
        endcase
    end

    assign o_Czas   = r_czas_q;
    assign o_Edycja = (r_stan_q != SPOCZYNEK);
    assign o_Pole   = (r_stan_q == EDYCJA_MIN);
    assign o_Gotowe = r_gotowe_q;

endmodule
`default_nettype wire

// File: tb/tb_nastawa_czasu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nastawa_czasu
//  Purpose  : Directed self-checking bench for nastawa_czasu (small timing).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nastawa_czasu;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  btn;
    logic [12:0] czas;
    logic        edycja;
    logic        pole;
    logic        gotowe;

    int n_checks = 0;
    int n_err    = 0;
    int p;
    int f;
    int b;
    int m_st;
    int m_min;
    int m_sek;
    int rep_t [11] = '{7, 8, 27, 28, 32, 33, 38, 43, 47, 48, 60};
    int rep_v [11] = '{0, 1, 1, 2, 2, 3, 4, 5, 5, 6, 6};

    always #5 clk = ~clk;

    nastawa_czasu #(
        .DEB_CYC    (4),
        .REP_DELAY  (20),
        .REP_PERIOD (5)
    ) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_Gora      (btn[0]),
        .i_Dol       (btn[1]),
        .i_Wybor     (btn[2]),
        .i_Zatwierdz (btn[3]),
        .o_Czas      (czas),
        .o_Edycja    (edycja),
        .o_Pole      (pole),
        .o_Gotowe    (gotowe)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input int bi, input int hold);
        btn[bi] = 1'b1;
        tick(hold);
        btn[bi] = 1'b0;
        tick(10);
    endtask

    // Counts o_Gotowe pulses and records the cycle of the first one.
    task automatic press_count(input int bi, input int hold, output int pulses, output int first);
        pulses = 0;
        first  = -1;
        btn[bi] = 1'b1;
        for (int t = 1; t <= hold + 10; t++) begin
            tick(1);
            if (gotowe) begin
                pulses++;
                if (first < 0) first = t;
            end
            if (t == hold) btn[bi] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        rst = 1'b1;
        btn = 4'b0000;
        tick(3);
        check("rst_czas", czas, 0);
        check("rst_edycja", edycja, 0);
        check("rst_pole", pole, 0);
        check("rst_gotowe", gotowe, 0);
        rst = 1'b0;
        tick(2);

        // Select: field state changes at cycle DEB+3 = 7.
        btn[2] = 1'b1;
        tick(6);
        check("sel_edycja_c6", edycja, 0);
        tick(1);
        check("sel_edycja_c7", edycja, 1);
        check("sel_pole", pole, 0);
        tick(3);
        btn[2] = 1'b0;
        tick(10);
        for (int i = 1; i <= 3; i++) begin
            press(0, 10);
            check("up_step", czas, i);
        end
        press_count(3, 10, p, f);
        check("commit_pulses", p, 1);
        check("commit_cycle", f, 7);
        check("commit_edycja", edycja, 0);
        check("commit_czas", czas, 3);

        // Minutes wrap down, seconds wrap both ways, no carry.
        do_reset();
        press(2, 10);
        press(2, 10);
        check("min_pole", pole, 1);
        press(1, 10);
        check("min_wrap_down", czas, 5940);
        press_count(3, 10, p, f);
        check("min_commit_pulses", p, 1);
        check("min_commit_czas", czas, 5940);
        check("min_commit_edycja", edycja, 0);
        press(2, 10);
        check("sek_pole", pole, 0);
        check("sek_edycja", edycja, 1);
        press(1, 10);
        check("sek_wrap_down_max", czas, 5999);
        press(0, 10);
        check("sek_wrap_up_nocarry", czas, 5940);

        // Glitches of 1..3 cycles are rejected; a clean press steps once.
        for (int w = 1; w <= 3; w++) begin
            btn[0] = 1'b1;
            tick(w);
            btn[0] = 1'b0;
            tick(2);
        end
        tick(10);
        check("glitch_nochange", czas, 5940);
        btn[0] = 1'b1;
        tick(7);
        check("clean_c7", czas, 5940);
        tick(1);
        check("clean_c8", czas, 5941);
        tick(2);
        btn[0] = 1'b0;
        tick(10);
        check("clean_once", czas, 5941);

        // Auto-repeat: events at 6, 26, 31, 36, 41, 46; released before 51.
        do_reset();
        press(2, 10);
        btn[0] = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            tick(1);
            if (t == 44) btn[0] = 1'b0;
            for (int k = 0; k < 11; k++) begin
                if (rep_t[k] == t) check($sformatf("rep_t%0d", t), czas, rep_v[k]);
            end
        end

        // Up and down together: ignored.
        btn[1:0] = 2'b11;
        tick(10);
        btn[1:0] = 2'b00;
        tick(10);
        check("updown_ignored", czas, 6);

        // Up with confirm: stepped value committed.
        btn[0] = 1'b1;
        btn[3] = 1'b1;
        tick(7);
        check("stepconf_gotowe", gotowe, 1);
        check("stepconf_edycja", edycja, 0);
        tick(1);
        check("stepconf_czas", czas, 7);
        check("stepconf_gotowe_end", gotowe, 0);
        tick(2);
        btn[0] = 1'b0;
        btn[3] = 1'b0;
        tick(10);

        // Select with confirm in minutes: confirm wins.
        press(2, 10);
        press(2, 10);
        check("selconf_pre_pole", pole, 1);
        btn[2] = 1'b1;
        btn[3] = 1'b1;
        tick(7);
        check("selconf_gotowe", gotowe, 1);
        check("selconf_edycja", edycja, 0);
        check("selconf_pole", pole, 0);
        tick(3);
        btn[2] = 1'b0;
        btn[3] = 1'b0;
        tick(10);
        check("selconf_idle", edycja, 0);

        // Reset mid-edit at 2:05.
        do_reset();
        press(2, 10);
        for (int i = 0; i < 5; i++) press(0, 10);
        press(2, 10);
        for (int i = 0; i < 2; i++) press(0, 10);
        check("mid_czas", czas, 125);
        check("mid_pole", pole, 1);
        rst = 1'b1;
        tick(1);
        check("midrst_czas", czas, 0);
        check("midrst_edycja", edycja, 0);
        check("midrst_pole", pole, 0);
        check("midrst_gotowe", gotowe, 0);
        rst = 1'b0;
        tick(3);
        check("midrst_gotowe_after", gotowe, 0);
        check("midrst_edycja_after", edycja, 0);

        // Random single presses against a behavioural model.
        do_reset();
        m_st  = 0;
        m_min = 0;
        m_sek = 0;
        for (int n = 0; n < 40; n++) begin
            b = $urandom_range(0, 3);
            press(b, 8);
            case (b)
                0: if (m_st == 1) m_sek = (m_sek == 59) ? 0 : m_sek + 1;
                   else if (m_st == 2) m_min = (m_min == 99) ? 0 : m_min + 1;
                1: if (m_st == 1) m_sek = (m_sek == 0) ? 59 : m_sek - 1;
                   else if (m_st == 2) m_min = (m_min == 0) ? 99 : m_min - 1;
                2: m_st = (m_st == 1) ? 2 : 1;
                default: m_st = 0;
            endcase
            check("rnd_czas", czas, m_min * 60 + m_sek);
            check("rnd_range", (czas <= 13'd5999), 1);
            check("rnd_edycja", edycja, (m_st != 0));
            check("rnd_pole", pole, (m_st == 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
